// File: rtl/clock_ctrl.sv
// 24-hour time-of-day controller: one-second prescaler, sec/min/hour counter
// chain with carries, and a key-driven set mode for hours and minutes.
module clock_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic [5:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       day_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [5:0]      hour_reg, hour_next;
    logic [5:0]      min_reg, min_next;
    logic [5:0]      sec_reg, sec_next;
    logic            sec_tick_reg, sec_tick_next;
    logic            day_tick_reg, day_tick_next;

    // State and datapath registers; async assert, the release is synchronised upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            presc_reg    <= '0;
            hour_reg     <= '0;
            min_reg      <= '0;
            sec_reg      <= '0;
            sec_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            hour_reg     <= hour_next;
            min_reg      <= min_next;
            sec_reg      <= sec_next;
            sec_tick_reg <= sec_tick_next;
            day_tick_reg <= day_tick_next;
        end
    end

    // Next-state: mode_key always wins over inc_key and over a pending RUN tick.
    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        hour_next     = hour_reg;
        min_next      = min_reg;
        sec_next      = sec_reg;
        sec_tick_next = 1'b0;
        day_tick_next = 1'b0;

        case (state_reg)
            RUN: begin
                if (mode_key) begin
                    // Entering set mode discards any tick due on this edge.
                    state_next = SET_HOUR;
                    presc_next = '0;
                end else if (presc_reg == PRESC_MAX) begin
                    presc_next    = '0;
                    sec_tick_next = 1'b1;
                    if (sec_reg == 6'd59) begin
                        sec_next = 6'd0;
                        if (min_reg == 6'd59) begin
                            min_next = 6'd0;
                            if (hour_reg == 6'd23) begin
                                hour_next     = 6'd0;
                                day_tick_next = 1'b1;
                            end else begin
                                hour_next = hour_reg + 6'd1;
                            end
                        end else begin
                            min_next = min_reg + 6'd1;
                        end
                    end else begin
                        sec_next = sec_reg + 6'd1;
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end

            SET_HOUR: begin
                presc_next = '0;
                if (mode_key) begin
                    state_next = SET_MIN;
                end else if (inc_key) begin
                    hour_next = (hour_reg == 6'd23) ? 6'd0 : hour_reg + 6'd1;
                end
            end

            SET_MIN: begin
                presc_next = '0;
                if (mode_key) begin
                    // Leaving set mode restarts the second from zero.
                    state_next = RUN;
                    sec_next   = 6'd0;
                end else if (inc_key) begin
                    min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
                end
            end

            default: begin
                state_next = RUN;
                presc_next = '0;
            end
        endcase
    end

    assign hour     = hour_reg;
    assign min      = min_reg;
    assign sec      = sec_reg;
    assign mode     = state_reg;
    assign sec_tick = sec_tick_reg;
    assign day_tick = day_tick_reg;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV = 4.
module tb_clock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mode_key;
    logic       inc_key;
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       sec_tick;
    logic       day_tick;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt;
    int day_cnt;

    clock_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_key (mode_key),
        .inc_key  (inc_key),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .mode     (mode),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, {26'd0, hour}, h);
        chk({tag, ".min"}, {26'd0, min}, m);
        chk({tag, ".sec"}, {26'd0, sec}, s);
        $display("%s: %0d:%0d:%0d mode=%0d", tag, hour, min, sec, mode);
    endtask

    // Advance n edges, landing 1 time unit after the last edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle key pulse sampled by the next edge.
    task automatic press(input logic m, input logic i);
        mode_key = m;
        inc_key  = i;
        @(posedge clk);
        #1;
        mode_key = 1'b0;
        inc_key  = 1'b0;
    endtask

    task automatic incs(input int n);
        repeat (n) press(1'b0, 1'b1);
    endtask

    // 12 edges from a fresh release: ticks after edges 4, 8, 12, ending at 00:00:03.
    task automatic run12(input string tag);
        for (int k = 1; k <= 12; k++) begin
            cycles(1);
            chk($sformatf("%s.sec_tick@%0d", tag, k), {31'd0, sec_tick}, (k % 4 == 0) ? 1 : 0);
        end
        chk_time(tag, 0, 0, 3);
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_key = 1'b0;
        inc_key  = 1'b0;

        // Reset state
        #1;
        chk_time("reset", 0, 0, 0);
        chk("reset.mode", {30'd0, mode}, 0);
        chk("reset.sec_tick", {31'd0, sec_tick}, 0);
        chk("reset.day_tick", {31'd0, day_tick}, 0);
        #21 rst_n = 1'b1;   // released between edges; next edge is edge 1

        // Free run
        run12("run12");

        // Hour edit with wrap: 25 increments from 0 land on 1
        press(1'b1, 1'b0);
        chk("sethour.mode", {30'd0, mode}, 1);
        tick_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            press(1'b0, 1'b1);
            if (sec_tick) tick_cnt++;
        end
        chk("sethour.mode_after", {30'd0, mode}, 1);
        chk_time("sethour", 1, 0, 3);
        chk("sethour.no_tick", tick_cnt, 0);

        // Minute edit with wrap: 58 then 3 more lands on 1
        press(1'b1, 1'b0);
        chk("setmin.mode", {30'd0, mode}, 2);
        incs(58);
        chk_time("setmin58", 1, 58, 3);
        incs(3);
        chk_time("setmin", 1, 1, 3);
        press(1'b1, 1'b0);
        chk("setmin_exit.mode", {30'd0, mode}, 0);
        chk_time("setmin_exit", 1, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            cycles(1);
            chk($sformatf("exit.sec_tick@%0d", k), {31'd0, sec_tick}, (k == 4) ? 1 : 0);
        end
        chk_time("exit_tick", 1, 1, 1);

        // Simultaneous keys on the edge a RUN tick is due: mode wins, tick dropped
        cycles(3);
        press(1'b1, 1'b1);
        chk("simul_run.mode", {30'd0, mode}, 1);
        chk("simul_run.sec_tick", {31'd0, sec_tick}, 0);
        chk_time("simul_run", 1, 1, 1);
        press(1'b1, 1'b1);
        chk("simul_hour.mode", {30'd0, mode}, 2);
        chk_time("simul_hour", 1, 1, 1);

        // Preload 23:59, run to 23:59:58, then through midnight
        press(1'b1, 1'b0);               // SET_MIN -> RUN, sec cleared
        press(1'b1, 1'b0);               // RUN -> SET_HOUR
        incs(22);
        press(1'b1, 1'b0);               // -> SET_MIN
        incs(58);
        press(1'b1, 1'b0);               // -> RUN
        chk("preload.mode", {30'd0, mode}, 0);
        chk_time("preload", 23, 59, 0);
        day_cnt = 0;
        for (int k = 0; k < 58 * 4; k++) begin
            cycles(1);
            if (day_tick) day_cnt++;
        end
        chk_time("pre_midnight", 23, 59, 58);
        for (int k = 1; k <= 8; k++) begin
            cycles(1);
            if (day_tick) day_cnt++;
            if (k == 4) chk_time("t235959", 23, 59, 59);
        end
        chk_time("midnight", 0, 0, 0);
        chk("midnight.day_tick", {31'd0, day_tick}, 1);
        chk("midnight.sec_tick", {31'd0, sec_tick}, 1);
        chk("midnight.day_count", day_cnt, 1);
        cycles(1);
        chk("midnight.day_tick_drop", {31'd0, day_tick}, 0);

        // Build 13:27:05 in SET_MIN, then async reset mid-cycle
        cycles(19);                      // 20 edges after midnight tick boundary
        chk_time("run5", 0, 0, 5);
        press(1'b1, 1'b0);
        incs(13);
        press(1'b1, 1'b0);
        incs(27);
        chk("preset.mode", {30'd0, mode}, 2);
        chk_time("preset", 13, 27, 5);
        #2 rst_n = 1'b0;
        #1;
        chk_time("async_rst", 0, 0, 0);
        chk("async_rst.mode", {30'd0, mode}, 0);
        chk("async_rst.sec_tick", {31'd0, sec_tick}, 0);
        chk("async_rst.day_tick", {31'd0, day_tick}, 0);
        #3 rst_n = 1'b1;
        run12("rerun12");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
